id_stage: RTL
=============

# id_stage

Decode stage of the RV32I 5-stage pipeline. It holds the IF/ID pipeline register with stall and flush, the 32x32 register file with a write-back port, the main and ALU decoder, and immediate extension. It drives every D-side input of the ID/EX register. Timing and control are fixed by that register's contract.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value held in IF/ID after reset or flush
- NOP_INSTR, 32'h0000_0013, instruction held in IF/ID after reset or flush (addi x0,x0,0)

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- InstrF  in  32  fetched instruction
- PCF, PCPlus4F  in  32  fetch PC and PC+4
- StallD  in  1  hold IF/ID contents
- FlushD  in  1  load NOP_INSTR/RESET_PC into IF/ID
- RegWriteW  in  1  write-back enable
- RdW  in  5  write-back destination
- ResultW  in  32  write-back data
- PCD, PCPlus4D, ImmExtD  out  32  to ID/EX
- RD1, RD2  out  32  register operands
- RdD, Rs1D, Rs2D  out  5  instr[11:7], [19:15], [24:20]
- funct3  out  3  instr[14:12]
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  out  1  control
- JalrD  out  1  JALR marker; EX uses it to select ALU result as target
- ResultSrcD  out  2  00 ALU, 01 memory, 10 PC+4, 11 PC+imm
- ALUControlD  out  5  ALU operation
- IllegalD  out  1  undecodable opcode or funct in IF/ID

## Operation
- IF/ID register priority: rst low > FlushD > StallD > load F values.
  - FlushD and StallD both high: flush wins.
- Register file: 32 x 32 bits.
  - Write on posedge when RegWriteW=1 and RdW!=0.
  - x0 always reads 0.
  - Write-first bypass: a read of RdW while RegWriteW=1 and RdW!=0 returns ResultW in the same cycle.
- Decode is combinational from the registered InstrD.
- R-type (0110011): RegWrite=1, ALUSrc=0, ResultSrc=00. ALUControl from funct3 and funct7[5].
- I-ALU (0010011): same as R-type with ALUSrc=1. funct7[5] applies only to SRAI.
  - SLLI/SRLI/SRAI with any other funct7 bits set: illegal.
- LOAD (0000011): RegWrite=1, ALUSrc=1, ADD, ResultSrc=01.
- STORE (0100011): MemWrite=1, ALUSrc=1, ADD, S-immediate.
- BRANCH (1100011): Branch=1, ALUSrc=0, SUB, B-immediate.
  - funct3 010 or 011: illegal.
- JAL (1101111): Jump=1, RegWrite=1, ResultSrc=10, J-immediate.
- JALR (1100111, funct3=000): Jump=1, Jalr=1, RegWrite=1, ALUSrc=1, ADD, ResultSrc=10.
- LUI (0110111): RegWrite=1, ALUSrc=1, PASSB, U-immediate.
- AUIPC (0010111): RegWrite=1, ResultSrc=11, U-immediate.
- Illegal: IllegalD=1 and all control outputs 0, so the instruction becomes a bubble.
- Immediates are sign-extended from instr[31]. U-immediate is instr[31:12] followed by 12 zeros.

## Timing
- Latency: F values presented before posedge n appear on all D outputs after posedge n, combinationally from IF/ID.
- Register write at posedge m is visible on RD1/RD2 combinationally during cycle m via bypass, then from storage.
- Reset values: IF/ID = NOP_INSTR/RESET_PC/RESET_PC+4, all registers 0. Outputs therefore decode as addi x0,x0,0:
  - RegWriteD=1, RdD=0, ALUSrcD=1, ALUControlD=ADD.
  - All other control outputs 0; RD1=RD2=0; ImmExtD=0; IllegalD=0.
- rst asserted mid-operation: immediate asynchronous clear; no write occurs in that cycle.
- Stall held for N cycles: D outputs are constant, except RD1/RD2, which follow write-back.

## Structure
- Package riscv_pkg holds:
  - opcode constants
  - ALUControl encoding: ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, SLT 00101, SLTU 00110, SLL 00111, SRL 01000, SRA 01001, PASSB 01010
  - ResultSrc encoding
  - NOP constant
- One sub-module: regfile (2 read ports, 1 write port, bypass).
- Decoder and immediate extension stay inline.

## Test plan
- Reset: rst low, then high, no F activity -> IllegalD=0, RegWriteD=1, RdD=0, PCD=0, RD1=RD2=0.
- InstrF=0x00500093 (addi x1,x0,5) loaded -> ALUSrcD=1, ALUControlD=00000, ImmExtD=5, RdD=1, RegWriteD=1.
- Write-back x1=0xDEADBEEF while InstrD=0x00108133 (add x2,x1,x1) -> RD1=RD2=0xDEADBEEF in the same cycle.
- Write-back RdW=0, ResultW=0x1234 -> subsequent read of x0 returns 0.
- StallD=1 for 3 cycles with changing InstrF -> PCD/InstrD-derived outputs unchanged. FlushD=1 together with StallD=1 -> NOP decode, PCD=RESET_PC.
- InstrF=0xFE000EE3 (beq, offset -4) -> BranchD=1, ALUControlD=00001, ImmExtD=0xFFFFFFFC. Opcode 0x7F -> IllegalD=1, all controls 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, ALU operation and result-select encodings,
// plus immediate extraction used by the decode stage.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'b00000,
    ALU_SUB   = 5'b00001,
    ALU_AND   = 5'b00010,
    ALU_OR    = 5'b00011,
    ALU_XOR   = 5'b00100,
    ALU_SLT   = 5'b00101,
    ALU_SLTU  = 5'b00110,
    ALU_SLL   = 5'b00111,
    ALU_SRL   = 5'b01000,
    ALU_SRA   = 5'b01001,
    ALU_PASSB = 5'b01010
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU   = 2'b00,
    RES_MEM   = 2'b01,
    RES_PC4   = 2'b10,
    RES_PCIMM = 2'b11
  } result_src_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J, IMM_U
  } imm_type_e;

  function automatic logic [31:0] imm_ext(input logic [31:0] instr, input imm_type_e kind);
    case (kind)
      IMM_I:   imm_ext = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm_ext = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm_ext = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   imm_ext = {instr[31:12], 12'h000};
      default: imm_ext = '0;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 register file: two combinational read ports, one write port, x0 hard-wired to zero,
// and write-first bypass so a same-cycle write-back is visible on the read ports.
module regfile
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] mem [32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 32; i++) mem[i] <= '0;
    end else if (we && wa != '0) begin
      mem[wa] <= wd;
    end
  end

  function automatic logic [31:0] read_port(input logic [4:0] ra);
    if (ra == '0)                  read_port = '0;
    else if (we && ra == wa)       read_port = wd;
    else                           read_port = mem[ra];
  endfunction

  assign rd1 = read_port(ra1);
  assign rd2 = read_port(ra2);

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID register with stall/flush, register file, main/ALU decoder
// and immediate extension feeding the ID/EX register.
module id_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrF,
  input  logic [31:0] PCF,
  input  logic [31:0] PCPlus4F,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic [31:0] ImmExtD,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [4:0]  RdD,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic [2:0]  funct3,
  output logic        RegWriteD,
  output logic        MemWriteD,
  output logic        JumpD,
  output logic        BranchD,
  output logic        ALUSrcD,
  output logic        JalrD,
  output logic [1:0]  ResultSrcD,
  output logic [4:0]  ALUControlD,
  output logic        IllegalD
);

  logic [31:0] instr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_d  <= NOP_INSTR;
      PCD      <= RESET_PC;
      PCPlus4D <= RESET_PC + 32'd4;
    end else if (FlushD) begin
      instr_d  <= NOP_INSTR;
      PCD      <= RESET_PC;
      PCPlus4D <= RESET_PC + 32'd4;
    end else if (!StallD) begin
      instr_d  <= InstrF;
      PCD      <= PCF;
      PCPlus4D <= PCPlus4F;
    end
  end

  assign RdD    = instr_d[11:7];
  assign Rs1D   = instr_d[19:15];
  assign Rs2D   = instr_d[24:20];
  assign funct3 = instr_d[14:12];

  regfile u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (Rs1D),
    .ra2 (Rs2D),
    .rd1 (RD1),
    .rd2 (RD2),
    .we  (RegWriteW),
    .wa  (RdW),
    .wd  (ResultW)
  );

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic        reg_write, mem_write, jump, branch, alu_src, jalr, illegal;
  alu_op_e     alu_op;
  result_src_e res_src;
  imm_type_e   imm_type;

  assign opcode = instr_d[6:0];
  assign funct7 = instr_d[31:25];

  always_comb begin
    reg_write = 1'b0;
    mem_write = 1'b0;
    jump      = 1'b0;
    branch    = 1'b0;
    alu_src   = 1'b0;
    jalr      = 1'b0;
    illegal   = 1'b0;
    alu_op    = ALU_ADD;
    res_src   = RES_ALU;
    imm_type  = IMM_NONE;
    case (opcode)
      OP_R, OP_IMM: begin
        reg_write = 1'b1;
        alu_src   = (opcode == OP_IMM);
        if (opcode == OP_IMM) imm_type = IMM_I;
        case (funct3)
          3'b000: if (opcode == OP_R && funct7[5]) alu_op = ALU_SUB;
                  else alu_op = ALU_ADD;
          3'b001: alu_op = ALU_SLL;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b101: if (funct7[5]) alu_op = ALU_SRA;
                  else alu_op = ALU_SRL;
          3'b110: alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
        // Immediate shifts carry shamt in [24:20]; only bit 30 (SRAI) may be set above it.
        if (opcode == OP_IMM) begin
          if (funct3 == 3'b001 && funct7 != 7'b0000000) illegal = 1'b1;
          if (funct3 == 3'b101 && {funct7[6], funct7[4:0]} != 6'b0) illegal = 1'b1;
        end
      end
      OP_LOAD: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        res_src   = RES_MEM;
        imm_type  = IMM_I;
      end
      OP_STORE: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        imm_type  = IMM_S;
      end
      OP_BRANCH: begin
        branch   = 1'b1;
        alu_op   = ALU_SUB;
        imm_type = IMM_B;
        if (funct3 == 3'b010 || funct3 == 3'b011) illegal = 1'b1;
      end
      OP_JAL: begin
        jump      = 1'b1;
        reg_write = 1'b1;
        res_src   = RES_PC4;
        imm_type  = IMM_J;
      end
      OP_JALR: begin
        jump      = 1'b1;
        jalr      = 1'b1;
        reg_write = 1'b1;
        alu_src   = 1'b1;
        res_src   = RES_PC4;
        imm_type  = IMM_I;
        if (funct3 != 3'b000) illegal = 1'b1;
      end
      OP_LUI: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = ALU_PASSB;
        imm_type  = IMM_U;
      end
      OP_AUIPC: begin
        reg_write = 1'b1;
        res_src   = RES_PCIMM;
        imm_type  = IMM_U;
      end
      default: illegal = 1'b1;
    endcase
    // An illegal instruction is turned into a bubble with no side effects.
    if (illegal) begin
      reg_write = 1'b0;
      mem_write = 1'b0;
      jump      = 1'b0;
      branch    = 1'b0;
      alu_src   = 1'b0;
      jalr      = 1'b0;
      alu_op    = ALU_ADD;
      res_src   = RES_ALU;
    end
  end

  assign RegWriteD   = reg_write;
  assign MemWriteD   = mem_write;
  assign JumpD       = jump;
  assign BranchD     = branch;
  assign ALUSrcD     = alu_src;
  assign JalrD       = jalr;
  assign IllegalD    = illegal;
  assign ALUControlD = alu_op;
  assign ResultSrcD  = res_src;
  assign ImmExtD     = imm_ext(instr_d, imm_type);

endmodule
